rvseed_test_ctrl: RTL and testbench

Self-checking program sequencer for the rvseed core. Loads up to `NUM_TESTS` program images from a valid/ready word stream into instruction memory. For each image it holds the core in reset, releases it, and watches a to-host result port. Each test is graded pass, fail or timeout, and the block keeps running counters; it sits between the program source (bench ROM or debug link) and `rvseed`'s imem write port and reset.

---
 rtl/rvseed_test_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rvseed_test_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvseed_test_ctrl.sv
// Program sequencer for rvseed: streams images into imem, pulses core reset, grades each run.
// Optional run-length capture on run_cycles is enabled by defining RVSEED_TC_CYCCNT_EN.
module rvseed_test_ctrl #(
  parameter int                   CPU_WIDTH = 32,
  parameter int                   IMEM_AW   = 8,
  parameter int                   NUM_TESTS = 4,
  parameter int                   TMO_W     = 16,
  parameter int                   RST_CYC   = 2,
  parameter logic [CPU_WIDTH-1:0] PASS_VAL  = 'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TMO_W-1:0]     timeout_lim,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [CPU_WIDTH-1:0] ld_data,
  input  logic                 ld_last,
  output logic                 imem_we,
  output logic [IMEM_AW-1:0]   imem_waddr,
  output logic [CPU_WIDTH-1:0] imem_wdata,
  output logic                 core_rst_n,
  input  logic                 tohost_valid,
  input  logic [CPU_WIDTH-1:0] tohost_data,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           test_idx,
  output logic [7:0]           pass_cnt,
  output logic [7:0]           fail_cnt,
  output logic [7:0]           tmo_cnt,
  output logic                 ovf_err,
  output logic [TMO_W-1:0]     run_cycles
);

  localparam int HOLD_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_HOLD, ST_RUN, ST_NEXT, ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [IMEM_AW-1:0]   addr_q, addr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [TMO_W-1:0]     run_cnt_q, run_cnt_d;
  logic [7:0]           test_idx_q, test_idx_d;
  logic [7:0]           pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;
  logic                 ovf_q, ovf_d;
  logic                 imem_we_q, imem_we_d;
  logic [IMEM_AW-1:0]   imem_waddr_q, imem_waddr_d;
  logic [CPU_WIDTH-1:0] imem_wdata_q, imem_wdata_d;
  logic                 ld_ready_q, ld_ready_d;
  logic                 core_rst_n_q, core_rst_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    addr_d       = addr_q;
    hold_d       = hold_q;
    run_cnt_d    = run_cnt_q;
    test_idx_d   = test_idx_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    tmo_d        = tmo_q;
    ovf_d        = ovf_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pass_d     = '0;
          fail_d     = '0;
          tmo_d      = '0;
          test_idx_d = '0;
          ovf_d      = 1'b0;
          addr_d     = '0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          imem_we_d    = 1'b1;
          imem_waddr_d = addr_q;
          imem_wdata_d = ld_data;
          addr_d       = addr_q + IMEM_AW'(1);
          // The top word is written but forces the image closed if it wasn't marked last.
          if (ld_last || (addr_q == '1)) begin
            state_d = ST_HOLD;
            hold_d  = '0;
            if (!ld_last) ovf_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYC - 1)) begin
          state_d   = ST_RUN;
          run_cnt_d = TMO_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        run_cnt_d = run_cnt_q + TMO_W'(1);
        if (tohost_valid) begin
          if (tohost_data == PASS_VAL) pass_d = sat_inc(pass_q);
          else                         fail_d = sat_inc(fail_q);
          state_d = ST_NEXT;
        end else if ((timeout_lim != '0) && (run_cnt_q == timeout_lim)) begin
          tmo_d   = sat_inc(tmo_q);
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        addr_d = '0;
        if (test_idx_q == 8'(NUM_TESTS - 1)) begin
          state_d = ST_DONE;
        end else begin
          test_idx_d = test_idx_q + 8'd1;
          state_d    = ST_LOAD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ld_ready_d   = (state_d == ST_LOAD);
    core_rst_n_d = (state_d == ST_RUN);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      hold_q       <= '0;
      run_cnt_q    <= '0;
      test_idx_q   <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      tmo_q        <= '0;
      ovf_q        <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      ld_ready_q   <= 1'b0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hold_q       <= hold_d;
      run_cnt_q    <= run_cnt_d;
      test_idx_q   <= test_idx_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      tmo_q        <= tmo_d;
      ovf_q        <= ovf_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      ld_ready_q   <= ld_ready_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

`ifdef RVSEED_TC_CYCCNT_EN
  logic [TMO_W-1:0] run_cycles_q, run_cycles_d;

  // Capture the run length on the exit edge of every graded test.
  always_comb begin
    run_cycles_d = run_cycles_q;
    if ((state_q == ST_RUN) && (state_d == ST_NEXT)) run_cycles_d = run_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) run_cycles_q <= '0;
    else     run_cycles_q <= run_cycles_d;
  end

  assign run_cycles = run_cycles_q;
`else
  assign run_cycles = '0;
`endif

  assign ld_ready   = ld_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign test_idx   = test_idx_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign tmo_cnt    = tmo_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_rvseed_test_ctrl.sv
// Directed bench for rvseed_test_ctrl (2 tests, 4-word imem): load, grading, timeout, overflow, reset.
module tb_rvseed_test_ctrl;

  localparam int CW = 32;
  localparam int AW = 2;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-1:0] timeout_lim;
  logic          ld_valid, ld_ready, ld_last;
  logic [CW-1:0] ld_data;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [CW-1:0] imem_wdata;
  logic          core_rst_n;
  logic          tohost_valid;
  logic [CW-1:0] tohost_data;
  logic          busy, done, ovf_err;
  logic [7:0]    test_idx, pass_cnt, fail_cnt, tmo_cnt;
  logic [TW-1:0] run_cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rvseed_test_ctrl #(
    .CPU_WIDTH(CW), .IMEM_AW(AW), .NUM_TESTS(2), .TMO_W(TW), .RST_CYC(2), .PASS_VAL(32'h1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .timeout_lim(timeout_lim),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .tohost_valid(tohost_valid), .tohost_data(tohost_data),
    .busy(busy), .done(done), .test_idx(test_idx),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .tmo_cnt(tmo_cnt),
    .ovf_err(ovf_err), .run_cycles(run_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rc(input logic [31:0] v);
`ifdef RVSEED_TC_CYCCNT_EN
    return v;
`else
    return (v & 32'h0);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; timeout_lim = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tohost_valid = 1'b0; tohost_data = '0;
    tick(); tick();
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_ready",    32'(ld_ready), 32'd0);
    check("rst_core",     32'(core_rst_n), 32'd0);
    check("rst_we",       32'(imem_we), 32'd0);
    check("rst_pass",     32'(pass_cnt), 32'd0);
    check("rst_runcyc",   32'(run_cycles), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Run 1: test 0 passes after a 3-word image with a gap, test 1 times out at 20.
    timeout_lim = 16'd20; start = 1'b1;
    tick(); start = 1'b0;
    check("load_ready", 32'(ld_ready), 32'd1);
    check("load_busy",  32'(busy), 32'd1);
    check("load_core",  32'(core_rst_n), 32'd0);
    ld_valid = 1'b1; ld_data = 32'h13;
    tick();
    check("w0_we",   32'(imem_we), 32'd1);
    check("w0_addr", 32'(imem_waddr), 32'd0);
    check("w0_data", imem_wdata, 32'h13);
    ld_valid = 1'b0;
    tick();
    check("bp_we", 32'(imem_we), 32'd0);
    ld_valid = 1'b1; ld_data = 32'h93;
    tick();
    check("w1_addr", 32'(imem_waddr), 32'd1);
    check("w1_data", imem_wdata, 32'h93);
    ld_data = 32'h6F; ld_last = 1'b1;
    tick();
    check("w2_addr",  32'(imem_waddr), 32'd2);
    check("w2_data",  imem_wdata, 32'h6F);
    check("w2_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0; ld_last = 1'b0;
    tick();
    check("hold_core", 32'(core_rst_n), 32'd0);
    check("hold_we",   32'(imem_we), 32'd0);
    tick();
    check("run_core", 32'(core_rst_n), 32'd1);
    tohost_valid = 1'b1; tohost_data = 32'h1;
    tick(); tohost_valid = 1'b0;
    check("t0_pass",   32'(pass_cnt), 32'd1);
    check("t0_fail",   32'(fail_cnt), 32'd0);
    check("t0_core",   32'(core_rst_n), 32'd0);
    check("t0_runcyc", 32'(run_cycles), exp_rc(32'd1));
    tick();
    check("t1_idx",   32'(test_idx), 32'd1);
    check("t1_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hAA;
    tick(); ld_valid = 1'b0; ld_last = 1'b0;
    check("t1_addr0", 32'(imem_waddr), 32'd0);
    tick(); tick();
    check("t1_run", 32'(core_rst_n), 32'd1);
    repeat (19) tick();
    check("t1_pre_tmo_core", 32'(core_rst_n), 32'd1);
    check("t1_pre_tmo_cnt",  32'(tmo_cnt), 32'd0);
    tick();
    check("t1_tmo_core",   32'(core_rst_n), 32'd0);
    check("t1_tmo_cnt",    32'(tmo_cnt), 32'd1);
    check("t1_tmo_runcyc", 32'(run_cycles), exp_rc(32'd20));
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy",  32'(busy), 32'd1);
    tohost_valid = 1'b1; tohost_data = 32'h1;
    tick(); tohost_valid = 1'b0;
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy2", 32'(busy), 32'd0);
    check("idle_tohost_ignored", 32'(pass_cnt), 32'd1);

    // Run 2: test 0 fails, test 1 reports pass on the timeout cycle.
    timeout_lim = 16'd3; start = 1'b1;
    tick(); start = 1'b0;
    check("r2_clr_pass", 32'(pass_cnt), 32'd0);
    check("r2_clr_tmo",  32'(tmo_cnt), 32'd0);
    check("r2_clr_idx",  32'(test_idx), 32'd0);
    ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h11;
    tick(); ld_valid = 1'b0; ld_last = 1'b0;
    tick(); tick();
    check("r2_run", 32'(core_rst_n), 32'd1);
    tohost_valid = 1'b1; tohost_data = 32'h5;
    tick(); tohost_valid = 1'b0;
    check("r2_fail", 32'(fail_cnt), 32'd1);
    check("r2_nopass", 32'(pass_cnt), 32'd0);
    tick();
    ld_valid = 1'b1; ld_last = 1'b1;
    tick(); ld_valid = 1'b0; ld_last = 1'b0;
    tick(); tick();
    tick(); tick();
    tohost_valid = 1'b1; tohost_data = 32'h1;
    tick(); tohost_valid = 1'b0;
    check("tie_pass",   32'(pass_cnt), 32'd1);
    check("tie_tmo",    32'(tmo_cnt), 32'd0);
    check("tie_runcyc", 32'(run_cycles), exp_rc(32'd3));
    tick();
    check("r2_done", 32'(done), 32'd1);
    tick();
    check("r2_idle", 32'(busy), 32'd0);

    // Run 3: overflow on a 4-word imem, then reset in the middle of a load.
    timeout_lim = '0; start = 1'b1;
    tick(); start = 1'b0;
    ld_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 32'h100 + 32'(i);
      tick();
      check("ovf_we",   32'(imem_we), 32'd1);
      check("ovf_addr", 32'(imem_waddr), 32'(i));
      check("ovf_data", imem_wdata, 32'h100 + 32'(i));
    end
    check("ovf_ready", 32'(ld_ready), 32'd0);
    check("ovf_flag",  32'(ovf_err), 32'd1);
    ld_data = 32'h104;
    tick();
    check("ovf_no_accept0", 32'(imem_we), 32'd0);
    ld_data = 32'h105;
    tick();
    check("ovf_no_accept1", 32'(imem_we), 32'd0);
    check("ovf_run",        32'(core_rst_n), 32'd1);
    ld_valid = 1'b0;
    repeat (5) tick();
    check("lim0_no_tmo",  32'(tmo_cnt), 32'd0);
    check("lim0_running", 32'(core_rst_n), 32'd1);
    tohost_valid = 1'b1; tohost_data = 32'h1;
    tick(); tohost_valid = 1'b0;
    tick();
    check("r3_t1_ready", 32'(ld_ready), 32'd1);
    check("r3_ovf_sticky", 32'(ovf_err), 32'd1);
    ld_valid = 1'b1; ld_data = 32'h55;
    tick();
    check("r3_w0_addr", 32'(imem_waddr), 32'd0);
    ld_data = 32'h56; rst = 1'b1;
    tick(); rst = 1'b0; ld_valid = 1'b0;
    check("mid_rst_ready", 32'(ld_ready), 32'd0);
    check("mid_rst_we",    32'(imem_we), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_ovf",   32'(ovf_err), 32'd0);
    check("mid_rst_pass",  32'(pass_cnt), 32'd0);
    check("mid_rst_idx",   32'(test_idx), 32'd0);
    check("mid_rst_waddr", 32'(imem_waddr), 32'd0);
    check("mid_rst_wdata", imem_wdata, 32'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    ld_valid = 1'b1; ld_data = 32'h99;
    tick(); ld_valid = 1'b0;
    check("reload_we",   32'(imem_we), 32'd1);
    check("reload_addr", 32'(imem_waddr), 32'd0);
    check("reload_data", imem_wdata, 32'h99);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
